mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised iterative multiply/divide unit with HI/LO result registers. It is the next-generation execution resource for the multi-cycle datapath: the ALU stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here and stalls its FSM on `busy`. The result width is generic. The unit is a radix-2 shift-add multiplier and restoring divider sharing one accumulator, with a start/busy/done handshake.

## Interface
- `WIDTH`, 32, operand/result width; must be ≥ 4 and even.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe; sampled only in IDLE.
- `op`  in  3  0=MULTU, 1=MULT, 2=DIVU, 3=DIV, 4=MTHI, 5=MTLO, 6–7=no-op.
- `a`  in  WIDTH  rs operand (multiplicand / dividend / MTxx data).
- `b`  in  WIDTH  rt operand (multiplier / divisor).
- `cancel`  in  1  abort strobe; present only with `MDU_CANCEL_EN`.
- `busy`  out  1  high while an iterative operation is in progress.
- `done`  out  1  one-cycle pulse when `hi`/`lo` take a new iterative result.
- `hi`  out  WIDTH  HI register: upper product or remainder.
- `lo`  out  WIDTH  LO register: lower product or quotient.

## Operation
- States: IDLE, RUN, FIX. Reset drives IDLE with `busy`=0, `done`=0, `hi`=0, `lo`=0, and all internal accumulators and the counter cleared.
- IDLE, `start`=1, op 0–3: latch operand magnitudes. Signed ops take absolute values and record `sa`/`sb`. Load the counter with WIDTH. Go to RUN.
- IDLE, `start`=1, op 4/5: write `a` into `hi`/`lo` at that edge. Stay in IDLE. No `busy`, no `done`.
- IDLE, `start`=1, op 6/7: ignored.
- RUN: one iteration per cycle and counter decrement. Go to FIX when the counter reaches 0.
  - Multiply iteration: if the multiplier LSB is set, add the multiplicand to the upper half; then shift the 2·WIDTH accumulator right by 1.
  - Divide iteration: shift {rem, quot} left by 1; trial-subtract the divisor; on non-negative, keep the difference and set quot LSB.
- FIX: apply sign correction, write `hi`/`lo`, pulse `done`, return to IDLE.
  - Signed product: negate the 2·WIDTH product when `sa`^`sb`.
  - Signed quotient: negate when `sa`^`sb`.
  - Signed remainder: takes the sign of the dividend (`sa`).
- Divide by zero, either signedness: `lo` = all ones, `hi` = `a`. Same latency as a normal divide.
- Signed overflow, MIN / −1: `lo` = MIN, `hi` = 0. This is two's-complement wrap; no trap.
- `start` while `busy`: ignored. Operands are not re-sampled and the in-flight result is unaffected.
- `hi`/`lo` hold their old value for the whole of RUN. The datapath may read them only when `busy`=0.

## Timing
- Start edge E0 → `busy`=1 from E0 through E(WIDTH+1). RUN occupies WIDTH cycles and FIX one cycle.
- `hi`, `lo` and `done` update at E(WIDTH+1). `done` is high for exactly one cycle after that edge. `busy` falls at the same edge.
- A new `start` is accepted in the cycle where `done`=1. Back-to-back throughput is one op per WIDTH+1 cycles.
- MTHI/MTLO latency: one edge.
- Reset asserted mid-RUN: immediate IDLE, with `hi`/`lo` cleared and no `done`.

## Configuration
- `MDU_CANCEL_EN` defined: `cancel` port exists.
  - `cancel`=1 in RUN or FIX returns the unit to IDLE at the next edge, with `busy`=0, no `done`, and `hi`/`lo` unchanged.
  - In IDLE, `cancel` has priority over `start`.
- `MDU_CANCEL_EN` undefined: no `cancel` port. Operations always run to completion.

## Test plan
- WIDTH=32, MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` one cycle, `busy` 33 cycles.
- MULT a=−7 (0xFFFFFFF9), b=3 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. DIV a=−7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU a=100, b=0 → `lo`=0xFFFFFFFF, `hi`=100. DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles → each register updated one edge later, with `busy`/`done` never asserted. A second `start` mid-RUN is ignored.
- Reset pulled low at iteration 10 of a DIVU → `busy`, `hi` and `lo` are 0 immediately, and the next op completes normally. With `MDU_CANCEL_EN`: `cancel` at iteration 5 → `busy`=0 next edge, `hi`/`lo` unchanged, no `done`.
- WIDTH=8: MULTU 200×200 → `hi`=0x9C, `lo`=0x40 after 9 cycles. DIVU 200/7 → `lo`=28, `hi`=4.

Source files
------------

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO result registers.
// One accumulator is shared by the radix-2 shift-add multiplier and the
// restoring divider. Issue uses a start/busy/done handshake, one iteration
// per cycle followed by a single sign-fix cycle.
// Optional feature: define MDU_CANCEL_EN to add the cancel abort input.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MDU_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     a_raw_q, a_raw_d;
  logic                 is_div_q, is_div_d;
  logic                 is_sgn_q, is_sgn_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 cancel_i;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     mul_add;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh;
  logic                 div_ge;
  logic [WIDTH-1:0]     rem_sub;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

`ifdef MDU_CANCEL_EN
  assign cancel_i = cancel;
`else
  assign cancel_i = 1'b0;
`endif

  // Operand magnitudes at issue: signed ops (odd op codes) strip the sign.
  always_comb begin
    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One iteration of each algorithm; the selected one is committed in RUN.
  always_comb begin
    mul_add  = acc_q[0] ? opnd_q : '0;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (rem_sh >= {1'b0, opnd_q});
    rem_sub  = rem_sh[WIDTH-1:0] - opnd_q;
    div_next = {(div_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
  end

  // Sign correction and the divide-by-zero result chosen for the FIX cycle.
  always_comb begin
    prod_fix = (is_sgn_q & (sa_q ^ sb_q)) ? -acc_q : acc_q;
    quot_fix = (is_sgn_q & (sa_q ^ sb_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = (is_sgn_q & sa_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (opnd_q == '0) begin
      fix_hi = a_raw_q;
      fix_lo = '1;
    end else begin
      fix_hi = rem_fix;
      fix_lo = quot_fix;
    end
  end

  // Next-state and datapath control: issue, iterate, fix up, abort.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    is_div_d = is_div_q;
    is_sgn_d = is_sgn_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cancel_i) begin
          state_d = S_IDLE;
        end else if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              state_d  = S_RUN;
              cnt_d    = CNT_INIT;
              is_div_d = op[1];
              is_sgn_d = op[0];
              sa_d     = a_neg;
              sb_d     = b_neg;
              a_raw_d  = a;
              if (op[1]) begin
                acc_d  = {{WIDTH{1'b0}}, a_mag};
                opnd_d = b_mag;
              end else begin
                acc_d  = {{WIDTH{1'b0}}, b_mag};
                opnd_d = a_mag;
              end
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        if (cancel_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_ONE) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel_i) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, accumulator and result registers; active-low asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      is_div_q <= 1'b0;
      is_sgn_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      is_div_q <= is_div_d;
      is_sgn_q <= is_sgn_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter at WIDTH=32 and WIDTH=8.
// Directed vector tables, hand-written multi-cycle sequences, and random
// operations checked against an arithmetic reference model.
module tb_mdu_iter;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, start8;
  logic [2:0]  op32, op8;
  logic [31:0] a32, b32, hi32, lo32;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy32, done32, busy8, done8;
`ifdef MDU_CANCEL_EN
  logic        cancel32, cancel8;
`endif

  int          n_cmp;
  int          n_fail;
  logic [31:0] cur_hi, cur_lo;
  logic [7:0]  cur_hi8, cur_lo8;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        poke;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .start (start32),
    .op    (op32),
    .a     (a32),
    .b     (b32),
`ifdef MDU_CANCEL_EN
    .cancel(cancel32),
`endif
    .busy  (busy32),
    .done  (done32),
    .hi    (hi32),
    .lo    (lo32)
  );

  mdu_iter #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
    .op    (op8),
    .a     (a8),
    .b     (b8),
`ifdef MDU_CANCEL_EN
    .cancel(cancel8),
`endif
    .busy  (busy8),
    .done  (done8),
    .hi    (hi8),
    .lo    (lo8)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void model(input int w, input logic [2:0] o,
                                input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] ch, input logic [31:0] cl,
                                output logic [31:0] nh, output logic [31:0] nl);
    longint unsigned mask, ux, uy, p;
    longint          sx, sy, q, r;
    mask = (64'd1 << w) - 64'd1;
    ux   = 64'(x) & mask;
    uy   = 64'(y) & mask;
    sx   = x[w-1] ? longint'(ux) - longint'(64'd1 << w) : longint'(ux);
    sy   = y[w-1] ? longint'(uy) - longint'(64'd1 << w) : longint'(uy);
    nh   = ch;
    nl   = cl;
    case (o)
      3'd0: begin
        p  = ux * uy;
        nh = 32'((p >> w) & mask);
        nl = 32'(p & mask);
      end
      3'd1: begin
        p  = longint'(sx * sy);
        nh = 32'((p >> w) & mask);
        nl = 32'(p & mask);
      end
      3'd2, 3'd3: begin
        if (uy == 0) begin
          nl = 32'(mask);
          nh = 32'(ux);
        end else if (o == 3'd2) begin
          nl = 32'(ux / uy);
          nh = 32'(ux % uy);
        end else begin
          q  = sx / sy;
          r  = sx % sy;
          nl = 32'(longint'(q) & longint'(mask));
          nh = 32'(longint'(r) & longint'(mask));
        end
      end
      3'd4: nh = 32'(ux);
      3'd5: nl = 32'(ux);
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op on the 32-bit unit and check timing, hold and result.
  task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] eh, input logic [31:0] el, input bit poke);
    int cyc;
    int busy_cyc;
    @(negedge clk);
    start32 = 1'b1; op32 = o; a32 = x; b32 = y;
    @(negedge clk);
    start32 = 1'b0; op32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
    if (o >= 3'd4) begin
      check_output("mt_busy", 64'(busy32), 64'd0);
      check_output("mt_done", 64'(done32), 64'd0);
      check_output("mt_hi", 64'(hi32), 64'(eh));
      check_output("mt_lo", 64'(lo32), 64'(el));
      cur_hi = eh;
      cur_lo = el;
      return;
    end
    cyc = 0;
    busy_cyc = 0;
    while (!done32 && cyc < 3 * W) begin
      if (busy32) busy_cyc++;
      if (cyc == W / 2) begin
        check_output("hold_hi", 64'(hi32), 64'(cur_hi));
        check_output("hold_lo", 64'(lo32), 64'(cur_lo));
      end
      if (poke && cyc == 5) begin
        start32 = 1'b1; op32 = 3'($urandom_range(0, 5));
      end
      if (poke && cyc == 6) start32 = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check_output("latency", 64'(cyc), 64'(W + 1));
    check_output("busy_cycles", 64'(busy_cyc), 64'(W + 1));
    check_output("busy_at_done", 64'(busy32), 64'd0);
    check_output("hi", 64'(hi32), 64'(eh));
    check_output("lo", 64'(lo32), 64'(el));
    cur_hi = eh;
    cur_lo = el;
    @(negedge clk);
    check_output("done_pulse", 64'(done32), 64'd0);
  endtask

  // Issue one op on the 8-bit unit and check latency and result.
  task automatic apply_stimulus8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                 input logic [7:0] eh, input logic [7:0] el);
    int cyc;
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    cyc = 0;
    if (o < 3'd4) begin
      while (!done8 && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check_output("w8_latency", 64'(cyc), 64'd9);
    end else begin
      check_output("w8_mt_busy", 64'(busy8), 64'd0);
    end
    check_output("w8_hi", 64'(hi8), 64'(eh));
    check_output("w8_lo", 64'(lo8), 64'(el));
    cur_hi8 = eh;
    cur_lo8 = el;
  endtask

  initial begin
    logic [31:0] x, y, eh, el;
    logic [2:0]  o;
    int          dn;
    n_cmp = 0; n_fail = 0;
    cur_hi = '0; cur_lo = '0; cur_hi8 = '0; cur_lo8 = '0;
    reset = 1'b0;
    start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
`ifdef MDU_CANCEL_EN
    cancel32 = 1'b0; cancel8 = 1'b0;
`endif

    vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{3'd1, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{3'd2, 32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5] = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b1};
    vecs[8] = '{3'd2, 32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999, 1'b0};
    vecs[9] = '{3'd0, 32'd12345,     32'd6789,      32'd0,         32'd83810205,  1'b0};

    repeat (3) @(negedge clk);
    check_output("rst_busy", 64'(busy32), 64'd0);
    check_output("rst_done", 64'(done32), 64'd0);
    check_output("rst_hi", 64'(hi32), 64'd0);
    check_output("rst_lo", 64'(lo32), 64'd0);
    reset = 1'b1;

    $display("[TB] directed vector table, WIDTH=32");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].poke);
    end

    $display("[TB] back-to-back MTHI / MTLO");
    @(negedge clk);
    start32 = 1'b1; op32 = 3'd4; a32 = 32'h1234_5678;
    @(negedge clk);
    check_output("mthi_hi", 64'(hi32), 64'h1234_5678);
    check_output("mthi_lo", 64'(lo32), 64'(cur_lo));
    check_output("mthi_busy", 64'(busy32), 64'd0);
    check_output("mthi_done", 64'(done32), 64'd0);
    op32 = 3'd5; a32 = 32'h9ABC_DEF0;
    @(negedge clk);
    start32 = 1'b0;
    check_output("mtlo_lo", 64'(lo32), 64'h9ABC_DEF0);
    check_output("mtlo_hi", 64'(hi32), 64'h1234_5678);
    check_output("mtlo_busy", 64'(busy32), 64'd0);
    check_output("mtlo_done", 64'(done32), 64'd0);
    cur_hi = 32'h1234_5678;
    cur_lo = 32'h9ABC_DEF0;

    $display("[TB] no-op codes leave HI/LO alone");
    apply_stimulus(3'd6, 32'hDEAD_BEEF, 32'h1, cur_hi, cur_lo, 1'b0);
    apply_stimulus(3'd7, 32'hCAFE_F00D, 32'h2, cur_hi, cur_lo, 1'b0);

    $display("[TB] reset during DIVU");
    @(negedge clk);
    start32 = 1'b1; op32 = 3'd2; a32 = 32'd1000000; b32 = 32'd7;
    @(negedge clk);
    start32 = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_output("rstmid_busy", 64'(busy32), 64'd0);
    check_output("rstmid_hi", 64'(hi32), 64'd0);
    check_output("rstmid_lo", 64'(lo32), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cur_hi = '0; cur_lo = '0; cur_hi8 = '0; cur_lo8 = '0;
    dn = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done32) dn++;
    end
    check_output("rstmid_no_done", 64'(dn), 64'd0);
    apply_stimulus(3'd2, 32'd1000000, 32'd7, 32'd1, 32'd142857, 1'b0);

`ifdef MDU_CANCEL_EN
    $display("[TB] cancel during MULTU");
    @(negedge clk);
    start32 = 1'b1; op32 = 3'd0; a32 = 32'd5; b32 = 32'd6;
    @(negedge clk);
    start32 = 1'b0;
    repeat (5) @(negedge clk);
    cancel32 = 1'b1;
    @(negedge clk);
    cancel32 = 1'b0;
    check_output("cancel_busy", 64'(busy32), 64'd0);
    check_output("cancel_hi", 64'(hi32), 64'(cur_hi));
    check_output("cancel_lo", 64'(lo32), 64'(cur_lo));
    dn = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done32) dn++;
    end
    check_output("cancel_no_done", 64'(dn), 64'd0);
    @(negedge clk);
    cancel32 = 1'b1; start32 = 1'b1; op32 = 3'd4; a32 = 32'hDEAD_0001;
    @(negedge clk);
    cancel32 = 1'b0; start32 = 1'b0;
    check_output("cancel_prio_hi", 64'(hi32), 64'(cur_hi));
    check_output("cancel_prio_busy", 64'(busy32), 64'd0);
`endif

    $display("[TB] random ops, WIDTH=32");
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      model(32, o, x, y, cur_hi, cur_lo, eh, el);
      apply_stimulus(o, x, y, eh, el, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] WIDTH=8 vectors and random ops");
    apply_stimulus8(3'd0, 8'd200, 8'd200, 8'h9C, 8'h40);
    apply_stimulus8(3'd2, 8'd200, 8'd7, 8'd4, 8'd28);
    apply_stimulus8(3'd3, 8'h80, 8'hFF, 8'h00, 8'h80);
    apply_stimulus8(3'd3, 8'hF9, 8'h00, 8'hF9, 8'hFF);
    for (int i = 0; i < 25; i++) begin
      o = 3'($urandom_range(0, 5));
      x = pick();
      y = pick();
      model(8, o, x, y, {24'd0, cur_hi8}, {24'd0, cur_lo8}, eh, el);
      apply_stimulus8(o, x[7:0], y[7:0], eh[7:0], el[7:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
